// File: rtl/digit_seq_pkg.sv
// Shared types and constants for the digit frame sequencer.
// Optional build macro used by the top: DIGIT_SEQ_TIMEOUT_EN (RUN watchdog).
package digit_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COPY  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_HOLD  = 3'd4
  } seq_state_e;

  // Digit reported when the classifier never answers
  localparam logic [3:0] RESULT_TIMEOUT = 4'hF;

  // Local pixel buffer geometry (classifier pixel_addr is 10 bits)
  localparam int BUF_DEPTH = 1024;
  localparam int BUF_AW    = 10;

  // Number of pixels in a square ROI of side dim
  function automatic int img_pixels(input int dim);
    return dim * dim;
  endfunction

endpackage

// File: rtl/digit_pixel_buffer.sv
// 1024x1 local ROI store: synchronous write from the copy engine,
// asynchronous read for the classifier's pixel_addr.
module digit_pixel_buffer
  import digit_seq_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic              wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic              rdata
);

  logic mem_r [0:BUF_DEPTH-1];

  // Capture one copied pixel per write strobe
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/digit_frame_sequencer.sv
// Sequences one digit-recognition run: copies the ROI out of the binarized
// frame buffer, holds the classifier in load while serving its pixel reads,
// then latches the returned digit.
// Build option: DIGIT_SEQ_TIMEOUT_EN adds a RUN watchdog (timeout_err, result 4'hF).
module digit_frame_sequencer
  import digit_seq_pkg::*;
#(
  parameter int IMG_DIM     = 28,
  parameter int FB_W        = 320,
  parameter int FB_AW       = 17,
  parameter int ROI_X       = 146,
  parameter int ROI_Y       = 106,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             fb_rd_en,
  output logic [FB_AW-1:0] fb_rd_addr,
  input  logic             fb_rd_data,
  output logic             cls_load,
  input  logic [9:0]       cls_pixel_addr,
  output logic             cls_pixel,
  input  logic             cls_complete,
  input  logic [3:0]       cls_number,
  output logic [3:0]       result,
  output logic             result_valid,
  output logic             timeout_err
);

  localparam int               IMG_PIXELS  = img_pixels(IMG_DIM);
  localparam int               CNT_W       = $clog2(IMG_DIM);
  // Address arithmetic is folded at elaboration; runtime only adds
  localparam logic [FB_AW-1:0]  ADDR_ORIGIN = FB_AW'(ROI_Y * FB_W + ROI_X);
  localparam logic [FB_AW-1:0]  ROW_STEP    = FB_AW'(FB_W - (IMG_DIM - 1));
  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(IMG_DIM - 1);
  localparam logic [BUF_AW-1:0] LAST_PIX    = BUF_AW'(IMG_PIXELS - 1);
  localparam logic [BUF_AW:0]   PIX_LIMIT   = (BUF_AW + 1)'(IMG_PIXELS);

  seq_state_e        state_r;
  seq_state_e        state_nx_s;
  logic [CNT_W-1:0]  row_r;
  logic [CNT_W-1:0]  col_r;
  logic [RD_LAT-1:0] vld_sr_r;
  logic [BUF_AW-1:0] wr_idx_r;
  logic              start_acc_s;
  logic              last_rd_s;
  logic              last_wr_s;
  logic              done_s;
  logic              timeout_s;
  logic              buf_rdata_s;
  logic              busy_r;
  logic              fb_rd_en_r;
  logic [FB_AW-1:0]  fb_rd_addr_r;
  logic              cls_load_r;
  logic [3:0]        result_r;
  logic              result_valid_r;

  assign last_rd_s = (state_r == ST_COPY) && (row_r == LAST_IDX) && (col_r == LAST_IDX);
  assign last_wr_s = vld_sr_r[RD_LAT-1] && (wr_idx_r == LAST_PIX);
  assign done_s    = (state_r == ST_RUN) && cls_complete;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; start is only honoured while idle or holding a result
  always_comb begin
    state_nx_s  = state_r;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HOLD: begin
        if (start) begin
          state_nx_s  = ST_COPY;
          start_acc_s = 1'b1;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_COPY: begin
        if (last_rd_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_COPY;
        end
      end
      ST_DRAIN: begin
        if (last_wr_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_RUN: begin
        if (cls_complete || timeout_s) begin
          state_nx_s = ST_HOLD;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Status strobes registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r     <= 1'b0;
      fb_rd_en_r <= 1'b0;
      cls_load_r <= 1'b0;
    end else begin
      busy_r     <= (state_nx_s == ST_COPY) || (state_nx_s == ST_DRAIN) || (state_nx_s == ST_RUN);
      fb_rd_en_r <= (state_nx_s == ST_COPY);
      cls_load_r <= (state_nx_s == ST_RUN);
    end
  end

  // Row-major ROI address walk: +1 inside a row, jump to next row start at row end
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_rd_addr_r <= {FB_AW{1'b0}};
      row_r        <= {CNT_W{1'b0}};
      col_r        <= {CNT_W{1'b0}};
    end else if (start_acc_s) begin
      fb_rd_addr_r <= ADDR_ORIGIN;
      row_r        <= {CNT_W{1'b0}};
      col_r        <= {CNT_W{1'b0}};
    end else if (state_r == ST_COPY) begin
      if (col_r == LAST_IDX) begin
        fb_rd_addr_r <= fb_rd_addr_r + ROW_STEP;
        col_r        <= {CNT_W{1'b0}};
        row_r        <= row_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        fb_rd_addr_r <= fb_rd_addr_r + {{(FB_AW-1){1'b0}}, 1'b1};
        col_r        <= col_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      fb_rd_addr_r <= fb_rd_addr_r;
    end
  end

  // Read-latency tracker and buffer write index
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr_r <= {RD_LAT{1'b0}};
      wr_idx_r <= {BUF_AW{1'b0}};
    end else begin
      vld_sr_r[0] <= fb_rd_en_r;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_r[i] <= vld_sr_r[i-1];
      end
      if (start_acc_s) begin
        wr_idx_r <= {BUF_AW{1'b0}};
      end else if (vld_sr_r[RD_LAT-1]) begin
        wr_idx_r <= wr_idx_r + {{(BUF_AW-1){1'b0}}, 1'b1};
      end else begin
        wr_idx_r <= wr_idx_r;
      end
    end
  end

  // Result latch; a new start withdraws the previous result
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r       <= 4'h0;
      result_valid_r <= 1'b0;
    end else if (done_s) begin
      result_r       <= cls_number;
      result_valid_r <= 1'b1;
    end else if (timeout_s) begin
      result_r       <= RESULT_TIMEOUT;
      result_valid_r <= 1'b1;
    end else if (start_acc_s) begin
      result_valid_r <= 1'b0;
    end else begin
      result_valid_r <= result_valid_r;
    end
  end

`ifdef DIGIT_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt_r;
  logic        timeout_err_r;

  // Watchdog counts RUN cycles, restarting on every RUN entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r != ST_RUN) begin
      wd_cnt_r <= 16'd0;
    end else begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end
  end

  assign timeout_s = (state_r == ST_RUN) && !cls_complete && (wd_cnt_r == 16'(TIMEOUT_CYC - 1));

  // Sticky timeout flag, withdrawn together with result_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
    end else if (start_acc_s) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  digit_pixel_buffer u_buf (
    .clk   (clk),
    .we    (vld_sr_r[RD_LAT-1]),
    .waddr (wr_idx_r),
    .wdata (fb_rd_data),
    .raddr (cls_pixel_addr),
    .rdata (buf_rdata_s)
  );

  assign cls_pixel    = ({1'b0, cls_pixel_addr} < PIX_LIMIT) ? buf_rdata_s : 1'b0;
  assign busy         = busy_r;
  assign fb_rd_en     = fb_rd_en_r;
  assign fb_rd_addr   = fb_rd_addr_r;
  assign cls_load     = cls_load_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;

endmodule
